// File: rtl/cv32e40x_txn_tracker.sv
// ---------------------------------------------------------------------------
// cv32e40x_txn_tracker
//
// Outstanding-transaction tracker sitting on the core side of the alignment
// checker and MPU. It counts in-flight bus requests, blocks issue once the
// in-flight limit is reached, remembers each request's sideband info in an
// in-order FIFO and pairs every returning response with the oldest request.
// It also produces the next-cycle "exactly one pending" indication used by
// the alignment checker to time its error responses.
//
// Parameters:
//   DEPTH   maximum outstanding transactions (1..4)
//   INFO_W  width of per-transaction sideband info (bit 0 = write enable)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   core_trans_valid_i      core request valid
//   core_trans_info_i       request sideband info
//   core_trans_ready_o      request accepted when high together with valid
//   down_trans_valid_o      request forwarded downstream
//   down_trans_ready_i      downstream ready
//   down_resp_valid_i       downstream response valid (single cycle, no stall)
//   down_resp_rdata_i       response read data
//   down_resp_bus_err_i     bus error
//   down_resp_mpu_err_i     MPU error
//   down_resp_align_err_i   alignment error
//   core_resp_valid_o       response to core
//   core_resp_rdata_o       read data, passed through
//   core_resp_err_o         0 = OK, 1 = bus, 2 = MPU, 3 = align
//   core_resp_info_o        info of the oldest outstanding request
//   one_txn_pend_n_o        exactly one transaction outstanding next cycle
//   outstanding_o           current outstanding count
//   empty_o                 outstanding count is zero
//   spurious_resp_o         response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module cv32e40x_txn_tracker #(
    parameter int DEPTH  = 2,
    parameter int INFO_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_trans_valid_i,
    input  logic [INFO_W-1:0] core_trans_info_i,
    output logic              core_trans_ready_o,
    output logic              down_trans_valid_o,
    input  logic              down_trans_ready_i,
    input  logic              down_resp_valid_i,
    input  logic [31:0]       down_resp_rdata_i,
    input  logic              down_resp_bus_err_i,
    input  logic              down_resp_mpu_err_i,
    input  logic              down_resp_align_err_i,
    output logic              core_resp_valid_o,
    output logic [31:0]       core_resp_rdata_o,
    output logic [1:0]        core_resp_err_o,
    output logic [INFO_W-1:0] core_resp_info_o,
    output logic              one_txn_pend_n_o,
    output logic [2:0]        outstanding_o,
    output logic              empty_o,
    output logic              spurious_resp_o
);

    localparam int                   PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [2:0]           CNT_MAX  = 3'(DEPTH);

    localparam logic [1:0]           ERR_OK    = 2'd0;
    localparam logic [1:0]           ERR_BUS   = 2'd1;
    localparam logic [1:0]           ERR_MPU   = 2'd2;
    localparam logic [1:0]           ERR_ALIGN = 2'd3;

    logic [2:0]        r_cnt;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [INFO_W-1:0] r_fifo [DEPTH];

    logic              w_full;
    logic              w_respOk;
    logic              w_slotAvail;
    logic              w_accept;
    logic [2:0]        w_cntNext;
    logic [PTR_W-1:0]  w_wptrNext;
    logic [PTR_W-1:0]  w_rptrNext;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A response in the same cycle frees a slot, so a full tracker may still
    // accept; the new entry lands in the slot being freed (wptr == rptr).
    assign w_full      = (r_cnt == CNT_MAX);
    assign w_respOk    = down_resp_valid_i && (r_cnt != 3'd0);
    assign w_slotAvail = !w_full || w_respOk;
    assign w_accept    = core_trans_valid_i && core_trans_ready_o;
    assign w_cntNext   = r_cnt + 3'(w_accept) - 3'(w_respOk);
    assign w_wptrNext  = ptrInc(r_wptr);
    assign w_rptrNext  = ptrInc(r_rptr);

    assign down_trans_valid_o = core_trans_valid_i && w_slotAvail;
    assign core_trans_ready_o = down_trans_ready_i && w_slotAvail;

    assign core_resp_valid_o  = w_respOk;
    assign core_resp_rdata_o  = down_resp_rdata_i;
    assign core_resp_info_o   = r_fifo[r_rptr];

    assign one_txn_pend_n_o   = (w_cntNext == 3'd1);
    assign outstanding_o      = r_cnt;
    assign empty_o            = (r_cnt == 3'd0);
    assign spurious_resp_o    = down_resp_valid_i && (r_cnt == 3'd0);

    // Error code priority: align over MPU over bus; forced to OK whenever no
    // response is being forwarded (including spurious responses).
    always_comb begin
        core_resp_err_o = ERR_OK;
        if (w_respOk) begin
            if (down_resp_align_err_i) begin
                core_resp_err_o = ERR_ALIGN;
            end else if (down_resp_mpu_err_i) begin
                core_resp_err_o = ERR_MPU;
            end else if (down_resp_bus_err_i) begin
                core_resp_err_o = ERR_BUS;
            end
        end
    end

    // Count and pointers; a spurious response leaves all of them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 3'd0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_cnt <= w_cntNext;
            if (w_accept) begin
                r_wptr <= w_wptrNext;
            end
            if (w_respOk) begin
                r_rptr <= w_rptrNext;
            end
        end
    end

    // Sideband storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wptr] <= core_trans_info_i;
        end
    end

endmodule

// File: tb/tb_cv32e40x_txn_tracker.sv
// ---------------------------------------------------------------------------
// tb_cv32e40x_txn_tracker
//
// Drives two trackers (DEPTH = 2 and DEPTH = 3) with the same stimulus.
// The reference model keeps only an outstanding count per instance; the
// request info is pushed into a per-instance scoreboard queue when a request
// is expected to be accepted, and an independent monitor pops and compares
// whenever a DUT presents a response.
// ---------------------------------------------------------------------------
module tb_cv32e40x_txn_tracker;

    localparam int INFO_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              coreValid = 1'b0;
    logic [INFO_W-1:0] coreInfo = '0;
    logic              downReady = 1'b0;
    logic              respValid = 1'b0;
    logic [31:0]       respRdata = '0;
    logic              busErr = 1'b0;
    logic              mpuErr = 1'b0;
    logic              alignErr = 1'b0;

    // index 0 -> DEPTH 2 instance, index 1 -> DEPTH 3 instance
    logic [1:0]        coreReady;
    logic [1:0]        downValid;
    logic [1:0]        coreRespValid;
    logic [1:0]        pendOne;
    logic [1:0]        emptyFlag;
    logic [1:0]        spurious;
    logic [31:0]       coreRespRdata [2];
    logic [1:0]        coreRespErr   [2];
    logic [INFO_W-1:0] coreRespInfo  [2];
    logic [2:0]        outstanding   [2];

    int                depthOf  [2] = '{2, 3};
    int                modelCnt [2] = '{0, 0};
    logic [INFO_W-1:0] sb0 [$];
    logic [INFO_W-1:0] sb1 [$];

    int total = 0;
    int bad   = 0;

    cv32e40x_txn_tracker #(.DEPTH(2), .INFO_W(INFO_W)) dut2 (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .core_trans_valid_i    (coreValid),
        .core_trans_info_i     (coreInfo),
        .core_trans_ready_o    (coreReady[0]),
        .down_trans_valid_o    (downValid[0]),
        .down_trans_ready_i    (downReady),
        .down_resp_valid_i     (respValid),
        .down_resp_rdata_i     (respRdata),
        .down_resp_bus_err_i   (busErr),
        .down_resp_mpu_err_i   (mpuErr),
        .down_resp_align_err_i (alignErr),
        .core_resp_valid_o     (coreRespValid[0]),
        .core_resp_rdata_o     (coreRespRdata[0]),
        .core_resp_err_o       (coreRespErr[0]),
        .core_resp_info_o      (coreRespInfo[0]),
        .one_txn_pend_n_o      (pendOne[0]),
        .outstanding_o         (outstanding[0]),
        .empty_o               (emptyFlag[0]),
        .spurious_resp_o       (spurious[0])
    );

    cv32e40x_txn_tracker #(.DEPTH(3), .INFO_W(INFO_W)) dut3 (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .core_trans_valid_i    (coreValid),
        .core_trans_info_i     (coreInfo),
        .core_trans_ready_o    (coreReady[1]),
        .down_trans_valid_o    (downValid[1]),
        .down_trans_ready_i    (downReady),
        .down_resp_valid_i     (respValid),
        .down_resp_rdata_i     (respRdata),
        .down_resp_bus_err_i   (busErr),
        .down_resp_mpu_err_i   (mpuErr),
        .down_resp_align_err_i (alignErr),
        .core_resp_valid_o     (coreRespValid[1]),
        .core_resp_rdata_o     (coreRespRdata[1]),
        .core_resp_err_o       (coreRespErr[1]),
        .core_resp_info_o      (coreRespInfo[1]),
        .one_txn_pend_n_o      (pendOne[1]),
        .outstanding_o         (outstanding[1]),
        .empty_o               (emptyFlag[1]),
        .spurious_resp_o       (spurious[1])
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input int k,
                           input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s depth=%0d t=%0t: got %0h expected %0h",
                     name, depthOf[k], $time, act, exp);
        end
    endtask

    function automatic logic [1:0] expErrCode();
        if (alignErr) return 2'd3;
        if (mpuErr)   return 2'd2;
        if (busErr)   return 2'd1;
        return 2'd0;
    endfunction

    // Compares the combinational outputs of instance k against the model and
    // records the expected response info when a request should be accepted.
    task automatic checkOutput(input int k, output int cntNext);
        int c;
        bit full;
        bit respOk;
        bit slotAvail;
        bit acc;
        c         = modelCnt[k];
        full      = (c == depthOf[k]);
        respOk    = respValid && (c != 0);
        slotAvail = !full || respOk;
        acc       = coreValid && downReady && slotAvail;
        cntNext   = c + int'(acc) - int'(respOk);
        compare("trans_ready",  k, 32'(coreReady[k]),     32'(downReady && slotAvail));
        compare("down_valid",   k, 32'(downValid[k]),     32'(coreValid && slotAvail));
        compare("resp_valid",   k, 32'(coreRespValid[k]), 32'(respOk));
        compare("one_pend",     k, 32'(pendOne[k]),       32'(cntNext == 1));
        compare("outstanding",  k, 32'(outstanding[k]),   32'(c));
        compare("empty",        k, 32'(emptyFlag[k]),     32'(c == 0));
        compare("spurious",     k, 32'(spurious[k]),      32'(respValid && (c == 0)));
        if (!respOk) begin
            compare("err_idle", k, 32'(coreRespErr[k]), 32'd0);
        end
        if (acc) begin
            if (k == 0) sb0.push_back(coreInfo);
            else        sb1.push_back(coreInfo);
        end
    endtask

    // One clock cycle of stimulus; called one time unit after a rising edge.
    task automatic applyStimulus(input bit v, input int info, input bit rdy,
                                 input bit rv, input logic [31:0] rdata,
                                 input bit be, input bit me, input bit ae);
        int nxt [2];
        coreValid = v;
        coreInfo  = INFO_W'(info);
        downReady = rdy;
        respValid = rv;
        respRdata = rdata;
        busErr    = be;
        mpuErr    = me;
        alignErr  = ae;
        #3;
        for (int k = 0; k < 2; k++) begin
            checkOutput(k, nxt[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            modelCnt[k] = nxt[k];
        end
        #1;
    endtask

    // Asynchronous reset mid-cycle; all tracked state is discarded.
    task automatic doReset();
        int nxt [2];
        coreValid = 1'b0;
        respValid = 1'b0;
        downReady = 1'b1;
        rst_n     = 1'b0;
        modelCnt  = '{0, 0};
        sb0.delete();
        sb1.delete();
        #3;
        for (int k = 0; k < 2; k++) begin
            checkOutput(k, nxt[k]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: pairs each presented response with the oldest
    // expected request and checks pass-through data and error priority.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (coreRespValid[k]) begin
                    logic [INFO_W-1:0] expInfo;
                    int sz;
                    sz = (k == 0) ? sb0.size() : sb1.size();
                    compare("sb_nonempty", k, 32'(sz != 0), 32'd1);
                    if (sz != 0) begin
                        expInfo = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        compare("resp_info",  k, 32'(coreRespInfo[k]), 32'(expInfo));
                        compare("resp_rdata", k, coreRespRdata[k], respRdata);
                        compare("resp_err",   k, 32'(coreRespErr[k]), 32'(expErrCode()));
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        doReset();

        // single read, then its response
        applyStimulus(1, 0, 1, 0, 32'h0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0);

        // three back-to-back requests, third blocked on the DEPTH=2 instance
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, i, 1, 0, 32'h0, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0);
        // full with response and new request in the same cycle
        applyStimulus(1, 3, 1, 1, 32'h1111_0001, 0, 0, 0);
        // drain, exercising error priority on the way
        applyStimulus(0, 0, 1, 1, 32'h2222_0002, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 32'h3333_0003, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 32'h4444_0004, 1, 0, 0);
        while (modelCnt[1] != 0) begin
            applyStimulus(0, 0, 1, 1, 32'h5555_0005, 0, 0, 0);
        end
        // spurious response with nothing outstanding
        applyStimulus(0, 0, 1, 1, 32'hBAD0_BAD0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0);

        // interleaved sequence across pointer wrap, reset mid-way
        for (int i = 0; i < 10; i++) begin
            if (i == 6) doReset();
            applyStimulus(1, i, 1, (i >= 2 && i != 6 && i != 7), 32'(i * 32'h0101_0101),
                          0, 0, 0);
        end
        while (modelCnt[1] != 0) begin
            applyStimulus(0, 0, 1, 1, 32'hCAFE_0000, 0, 0, 0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                doReset();
            end
            applyStimulus($urandom_range(0, 99) < 60, int'($urandom_range(0, 15)),
                          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40,
                          $urandom, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end
        while (modelCnt[1] != 0 || modelCnt[0] != 0) begin
            applyStimulus(0, 0, 1, 1, 32'hF00D_0000, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0);

        compare("sb_left", 0, 32'(sb0.size()), 32'd0);
        compare("sb_left", 1, 32'(sb1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
